// File: rtl/lcd_pkg.sv
// Shared types, timing helper and HD44780 constants for the LCD bus engine.
// Pure declarations; no latency or flow control of its own.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_E_LOW,
    ST_RESP
  } lcd_bus_state_t;

  localparam int BUSY_BIT = 7;

  // Round up so a phase is never shorter than the requested time.
  function automatic int ns_to_cycles(input longint freq, input longint ns);
    longint c;
    c = (freq * ns + longint'(999_999_999)) / longint'(1_000_000_000);
    return (c < 1) ? 1 : int'(c);
  endfunction

  // Pin image for one write beat; 4-bit mode drives [7:4] only.
  function automatic logic [7:0] beat_data(input logic [7:0] d, input logic mode8,
                                           input logic second);
    if (mode8) return d;
    return second ? {d[3:0], 4'h0} : {d[7:4], 4'h0};
  endfunction

endpackage

// File: rtl/lcd_bus_if.sv
// Command/response port between the LCD sequencer (master) and the bus engine (slave).
// Valid/ready on commands, single-cycle rsp_valid pulse on completion.
interface lcd_bus_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_rs;
  logic       cmd_rnw;
  logic       cmd_nibble_only;
  logic       cmd_wait_busy;
  logic       mode8bit;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;

  modport master (
    output cmd_valid, cmd_data, cmd_rs, cmd_rnw, cmd_nibble_only, cmd_wait_busy, mode8bit,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_rs, cmd_rnw, cmd_nibble_only, cmd_wait_busy, mode8bit,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded N-cycle phase.
// Reload on the done cycle chains phases back to back with no gap.
module lcd_phase_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780 byte read/write engine over a 4/8-bit bus; beats*(S+P+H) cycles accept-to-rsp, plus polls.
// One command at a time: cmd_ready only in IDLE; LCD_POLL_TIMEOUT_EN bounds busy polling to MAX_POLLS.
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int T_SETUP_NS  = 2000,
  parameter int T_PULSE_NS  = 1000,
  parameter int T_HOLD_NS   = 2000,
  parameter int MAX_POLLS   = 1000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  lcd_bus_if.slave   bus,
  output logic [7:0] LCD_D_OUT,
  output logic       LCD_D_OE,
  input  logic [7:0] LCD_D_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E
);

  localparam int S_CYC   = ns_to_cycles(CLK_FREQ_HZ, T_SETUP_NS);
  localparam int P_CYC   = ns_to_cycles(CLK_FREQ_HZ, T_PULSE_NS);
  localparam int H_CYC   = ns_to_cycles(CLK_FREQ_HZ, T_HOLD_NS);
  localparam int SP_MAX  = (S_CYC > P_CYC) ? S_CYC : P_CYC;
  localparam int MAX_CYC = (SP_MAX > H_CYC) ? SP_MAX : H_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  lcd_bus_state_t state_q;
  logic           beat_q;
  logic           mode8_q;
  logic           rnw_q;
  logic           nib_q;
  logic           wait_q;
  logic           polling_q;
  logic [7:0]     data_q;
  logic [7:0]     rdata_q;
  logic           cmd_ready_q;
  logic           busy_q;
  logic           rsp_valid_q;
  logic [7:0]     rsp_data_q;

  logic           t_load;
  logic [TW-1:0]  t_val;
  logic           t_done;
  logic           last_beat;
  logic           poll_busy;
  logic           timeout_hit;
  logic           restart;

`ifdef LCD_POLL_TIMEOUT_EN
  localparam int PCW = $clog2(MAX_POLLS + 1);
  logic [PCW-1:0] poll_cnt_q;
  logic           timeout_q;

  assign timeout_hit     = poll_busy && (poll_cnt_q == PCW'(MAX_POLLS - 1));
  assign bus.rsp_timeout = timeout_q;
`else
  logic unused_max_polls;

  assign unused_max_polls = ^MAX_POLLS;
  assign timeout_hit      = 1'b0;
  assign bus.rsp_timeout  = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Status polls always clock both nibbles; nibble_only trims writes only.
  assign last_beat = mode8_q | beat_q | (nib_q & ~rnw_q & ~polling_q);
  assign poll_busy = rdata_q[BUSY_BIT];
  assign restart   = !last_beat || (polling_q ? (poll_busy && !timeout_hit) : wait_q);

  always_comb begin
    t_load = 1'b0;
    t_val  = TW'(S_CYC);
    case (state_q)
      ST_IDLE:   t_load = bus.cmd_valid;
      ST_SETUP:  begin t_load = t_done; t_val = TW'(P_CYC); end
      ST_E_HIGH: begin t_load = t_done; t_val = TW'(H_CYC); end
      ST_E_LOW:  t_load = t_done & restart;
      default:   t_load = 1'b0;
    endcase
  end

  lcd_phase_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      beat_q      <= 1'b0;
      mode8_q     <= 1'b0;
      rnw_q       <= 1'b0;
      nib_q       <= 1'b0;
      wait_q      <= 1'b0;
      polling_q   <= 1'b0;
      data_q      <= 8'h00;
      rdata_q     <= 8'h00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      LCD_D_OUT   <= 8'h00;
      LCD_D_OE    <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_E       <= 1'b0;
`ifdef LCD_POLL_TIMEOUT_EN
      poll_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            mode8_q     <= bus.mode8bit;
            rnw_q       <= bus.cmd_rnw;
            nib_q       <= bus.cmd_nibble_only;
            wait_q      <= bus.cmd_wait_busy;
            data_q      <= bus.cmd_data;
            beat_q      <= 1'b0;
            polling_q   <= 1'b0;
            rdata_q     <= 8'h00;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            LCD_RS      <= bus.cmd_rs;
            LCD_RW      <= bus.cmd_rnw;
            LCD_D_OE    <= !bus.cmd_rnw;
            LCD_D_OUT   <= bus.cmd_rnw ? 8'h00 : beat_data(bus.cmd_data, bus.mode8bit, 1'b0);
`ifdef LCD_POLL_TIMEOUT_EN
            poll_cnt_q  <= '0;
`endif
            state_q     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (t_done) begin
            LCD_E   <= 1'b1;
            state_q <= ST_E_HIGH;
          end
        end

        ST_E_HIGH: begin
          if (t_done) begin
            LCD_E <= 1'b0;
            if (mode8_q) rdata_q <= LCD_D_IN;
            else if (beat_q) rdata_q[3:0] <= LCD_D_IN[7:4];
            else rdata_q[7:4] <= LCD_D_IN[7:4];
            state_q <= ST_E_LOW;
          end
        end

        ST_E_LOW: begin
          if (t_done) begin
            if (!last_beat) begin
              beat_q    <= 1'b1;
              LCD_D_OUT <= (rnw_q || polling_q) ? 8'h00 : beat_data(data_q, mode8_q, 1'b1);
              state_q   <= ST_SETUP;
            end else if (polling_q) begin
`ifdef LCD_POLL_TIMEOUT_EN
              poll_cnt_q <= poll_cnt_q + PCW'(1);
              timeout_q  <= timeout_hit;
`endif
              if (restart) begin
                beat_q  <= 1'b0;
                state_q <= ST_SETUP;
              end else begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rdata_q;
                state_q     <= ST_RESP;
              end
            end else if (wait_q) begin
              // RW rises on the same edge OE drops, so the pins never contend.
              polling_q <= 1'b1;
              beat_q    <= 1'b0;
              LCD_RS    <= 1'b0;
              LCD_RW    <= 1'b1;
              LCD_D_OE  <= 1'b0;
              LCD_D_OUT <= 8'h00;
              state_q   <= ST_SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rnw_q ? rdata_q : 8'h00;
              state_q     <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= 8'h00;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          LCD_E       <= 1'b0;
          LCD_D_OE    <= 1'b0;
          LCD_RW      <= 1'b0;
          LCD_RS      <= 1'b0;
          LCD_D_OUT   <= 8'h00;
`ifdef LCD_POLL_TIMEOUT_EN
          timeout_q   <= 1'b0;
`endif
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine at default timing (S=100, P=50, H=100).
// A small LCD pin model answers reads from a per-test table.
module tb_lcd_bus_engine;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] LCD_D_OUT;
  logic       LCD_D_OE;
  logic [7:0] LCD_D_IN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;

  always #5 CLK = ~CLK;

  lcd_bus_if bus ();

`ifdef LCD_POLL_TIMEOUT_EN
  lcd_bus_engine #(.MAX_POLLS(4)) dut (
`else
  lcd_bus_engine dut (
`endif
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .LCD_D_OUT (LCD_D_OUT),
    .LCD_D_OE  (LCD_D_OE),
    .LCD_D_IN  (LCD_D_IN),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_E     (LCD_E)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] din_tab [16];
  int         din_idx;

  int         w_rsp_cycle, w_rsp_count, w_pulses, w_bad_safety, w_bad_busy;
  logic [7:0] w_rsp_data;
  logic       w_rsp_timeout;
  logic [5:0] w_post;
  int         p_start [8];
  int         p_len   [8];
  logic [7:0] p_dout  [8];
  logic       p_rw    [8];
  logic       p_oe    [8];
  logic       p_rs    [8];

  // Issue one command and record pin activity per cycle; k counts cycles after the accept edge.
  task automatic run_op(input logic [7:0] d, input logic rs, input logic rnw,
                        input logic nib, input logic wb, input logic m8);
    int   k;
    logic e_prev;
    w_rsp_cycle = -1; w_rsp_count = 0; w_pulses = 0;
    w_bad_safety = 0; w_bad_busy = 0; w_post = '0;
    w_rsp_data = '0; w_rsp_timeout = 1'b0;
    din_idx = 0; e_prev = 1'b0; k = 0;
    @(negedge CLK);
    bus.cmd_data = d; bus.cmd_rs = rs; bus.cmd_rnw = rnw;
    bus.cmd_nibble_only = nib; bus.cmd_wait_busy = wb; bus.mode8bit = m8;
    bus.cmd_valid = 1'b1;
    @(posedge CLK);
    while (k < 6000) begin
      @(negedge CLK);
      if (k == 0) bus.cmd_valid = 1'b0;
      if (LCD_D_OE && LCD_RW) w_bad_safety++;
      if (LCD_E && !e_prev) begin
        if (w_pulses < 8) begin
          p_start[w_pulses] = k; p_len[w_pulses] = 0; p_dout[w_pulses] = LCD_D_OUT;
          p_rw[w_pulses] = LCD_RW; p_oe[w_pulses] = LCD_D_OE; p_rs[w_pulses] = LCD_RS;
        end
        if (LCD_RW) begin
          LCD_D_IN = din_tab[din_idx];
          if (din_idx < 15) din_idx++;
        end
        w_pulses++;
      end
      if (LCD_E && w_pulses >= 1 && w_pulses <= 8) p_len[w_pulses-1]++;
      e_prev = LCD_E;
      if (bus.rsp_valid) begin
        w_rsp_count++;
        if (w_rsp_cycle < 0) begin
          w_rsp_cycle = k; w_rsp_data = bus.rsp_data; w_rsp_timeout = bus.rsp_timeout;
        end
      end
      if ((w_rsp_cycle < 0 || k == w_rsp_cycle) && !bus.busy) w_bad_busy++;
      if (w_rsp_cycle >= 0 && k == w_rsp_cycle + 1) begin
        w_post = {bus.cmd_ready, bus.busy, bus.rsp_valid, LCD_E, LCD_D_OE, LCD_RW};
        break;
      end
      k++;
    end
    if (w_rsp_cycle < 0) begin
      tests++; fails++;
      $display("FAIL op_no_response: no rsp_valid within 6000 cycles");
    end
  endtask

  task automatic test_reset();
    logic [23:0] got;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    got = {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data,
           LCD_E, LCD_RS, LCD_RW, LCD_D_OE, LCD_D_OUT};
    tests++;
    if (got !== 24'h800000) begin
      fails++; $display("FAIL reset_outputs: got %h want 800000", got);
    end
  endtask

  task automatic test_write8();
    run_op(8'h38, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (w_pulses !== 1) begin fails++; $display("FAIL w8_pulses: got %0d want 1", w_pulses); end
    tests++; if (p_start[0] !== 100) begin fails++; $display("FAIL w8_e_start: got %0d want 100", p_start[0]); end
    tests++; if (p_len[0] !== 50) begin fails++; $display("FAIL w8_e_len: got %0d want 50", p_len[0]); end
    tests++; if ({p_dout[0], p_oe[0], p_rw[0], p_rs[0]} !== {8'h38, 3'b100}) begin
      fails++; $display("FAIL w8_pins: dout=%h oe=%b rw=%b rs=%b want 38 1 0 0", p_dout[0], p_oe[0], p_rw[0], p_rs[0]);
    end
    tests++; if (w_rsp_cycle !== 250) begin fails++; $display("FAIL w8_rsp_cycle: got %0d want 250", w_rsp_cycle); end
    tests++; if ({w_rsp_data, w_rsp_timeout} !== 9'h000) begin
      fails++; $display("FAIL w8_rsp_data: got %h/%b want 00/0", w_rsp_data, w_rsp_timeout);
    end
    tests++; if (w_bad_busy !== 0) begin fails++; $display("FAIL w8_busy: %0d cycles low, want 0", w_bad_busy); end
    tests++; if (w_post !== 6'b100000) begin fails++; $display("FAIL w8_post_idle: got %b want 100000", w_post); end
  endtask

  task automatic test_write4();
    run_op(8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (w_pulses !== 2) begin fails++; $display("FAIL w4_pulses: got %0d want 2", w_pulses); end
    tests++; if ({p_dout[0], p_dout[1]} !== 16'h4010) begin
      fails++; $display("FAIL w4_beats: got %h %h want 40 10", p_dout[0], p_dout[1]);
    end
    tests++; if ({p_rs[0], p_rs[1], p_oe[0], p_oe[1]} !== 4'b1111) begin
      fails++; $display("FAIL w4_rs_oe: got %b%b%b%b want 1111", p_rs[0], p_rs[1], p_oe[0], p_oe[1]);
    end
    tests++; if (p_start[1] !== 350) begin fails++; $display("FAIL w4_e2_start: got %0d want 350", p_start[1]); end
    tests++; if (w_rsp_cycle !== 500) begin fails++; $display("FAIL w4_rsp_cycle: got %0d want 500", w_rsp_cycle); end
    tests++; if (w_rsp_data !== 8'h00) begin fails++; $display("FAIL w4_rsp_data: got %h want 00", w_rsp_data); end
  endtask

  task automatic test_nibble_only();
    run_op(8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (w_pulses !== 1) begin fails++; $display("FAIL nib_pulses: got %0d want 1", w_pulses); end
    tests++; if (p_dout[0] !== 8'h30) begin fails++; $display("FAIL nib_dout: got %h want 30", p_dout[0]); end
    tests++; if (w_rsp_cycle !== 250) begin fails++; $display("FAIL nib_rsp_cycle: got %0d want 250", w_rsp_cycle); end
  endtask

  task automatic test_poll8();
    din_tab[0] = 8'h85; din_tab[1] = 8'h85; din_tab[2] = 8'h85; din_tab[3] = 8'h05;
    run_op(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests++; if (w_pulses !== 5) begin fails++; $display("FAIL p8_pulses: got %0d want 5", w_pulses); end
    for (int i = 1; i < 5; i++) begin
      tests++;
      if ({p_rw[i], p_oe[i], p_rs[i]} !== 3'b100) begin
        fails++; $display("FAIL p8_poll%0d_pins: rw/oe/rs=%b%b%b want 100", i, p_rw[i], p_oe[i], p_rs[i]);
      end
    end
    tests++; if (p_start[4] !== 1100) begin fails++; $display("FAIL p8_poll4_start: got %0d want 1100", p_start[4]); end
    tests++; if (w_rsp_cycle !== 1250) begin fails++; $display("FAIL p8_rsp_cycle: got %0d want 1250", w_rsp_cycle); end
    tests++; if ({w_rsp_data, w_rsp_timeout} !== {8'h05, 1'b0}) begin
      fails++; $display("FAIL p8_rsp: got %h/%b want 05/0", w_rsp_data, w_rsp_timeout);
    end
    tests++; if (w_bad_safety !== 0) begin fails++; $display("FAIL p8_bus_safety: %0d cycles OE&RW, want 0", w_bad_safety); end
  endtask

  task automatic test_poll4();
    din_tab[0] = 8'h80; din_tab[1] = 8'h30; din_tab[2] = 8'h00; din_tab[3] = 8'h50;
    run_op(8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (w_pulses !== 6) begin fails++; $display("FAIL p4_pulses: got %0d want 6", w_pulses); end
    tests++; if (w_rsp_cycle !== 1500) begin fails++; $display("FAIL p4_rsp_cycle: got %0d want 1500", w_rsp_cycle); end
    tests++; if (w_rsp_data !== 8'h05) begin fails++; $display("FAIL p4_rsp_data: got %h want 05", w_rsp_data); end
  endtask

  task automatic test_read4();
    din_tab[0] = 8'hA5; din_tab[1] = 8'h7C;
    run_op(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (w_pulses !== 2) begin fails++; $display("FAIL r4_pulses: got %0d want 2", w_pulses); end
    tests++; if ({p_rw[0], p_oe[0], p_rs[0], p_rw[1], p_oe[1], p_rs[1]} !== 6'b101101) begin
      fails++; $display("FAIL r4_pins: got %b%b%b %b%b%b want 101 101", p_rw[0], p_oe[0], p_rs[0], p_rw[1], p_oe[1], p_rs[1]);
    end
    tests++; if (w_rsp_cycle !== 500) begin fails++; $display("FAIL r4_rsp_cycle: got %0d want 500", w_rsp_cycle); end
    tests++; if (w_rsp_data !== 8'hA7) begin fails++; $display("FAIL r4_rsp_data: got %h want a7", w_rsp_data); end
    tests++; if (w_bad_safety !== 0) begin fails++; $display("FAIL r4_bus_safety: %0d cycles OE&RW, want 0", w_bad_safety); end
  endtask

`ifdef LCD_POLL_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 16; i++) din_tab[i] = 8'h80;
    run_op(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests++; if (w_pulses !== 5) begin fails++; $display("FAIL to_pulses: got %0d want 5", w_pulses); end
    tests++; if (w_rsp_cycle !== 1250) begin fails++; $display("FAIL to_rsp_cycle: got %0d want 1250", w_rsp_cycle); end
    tests++; if ({w_rsp_data, w_rsp_timeout} !== {8'h80, 1'b1}) begin
      fails++; $display("FAIL to_rsp: got %h/%b want 80/1", w_rsp_data, w_rsp_timeout);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int   k, k1, k2;
    logic rdy_at, busy_at;
    k = 0; k1 = -1; k2 = -1; rdy_at = 1'b0; busy_at = 1'b0;
    @(negedge CLK);
    bus.cmd_data = 8'h38; bus.cmd_rs = 1'b0; bus.cmd_rnw = 1'b0;
    bus.cmd_nibble_only = 1'b0; bus.cmd_wait_busy = 1'b0; bus.mode8bit = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge CLK);
    while (k < 2000 && k2 < 0) begin
      @(negedge CLK);
      if (bus.rsp_valid) begin
        if (k1 < 0) k1 = k;
        else begin k2 = k; bus.cmd_valid = 1'b0; end
      end
      if (k1 >= 0 && k == k1 + 1) rdy_at = bus.cmd_ready;
      if (k1 >= 0 && k == k1 + 2) busy_at = bus.busy & ~bus.cmd_ready;
      k++;
    end
    bus.cmd_valid = 1'b0;
    tests++; if (k1 !== 250) begin fails++; $display("FAIL b2b_rsp1: got %0d want 250", k1); end
    tests++; if ({rdy_at, busy_at} !== 2'b11) begin
      fails++; $display("FAIL b2b_reaccept: ready@251=%b busy@252=%b want 1 1", rdy_at, busy_at);
    end
    tests++; if (k2 !== 502) begin fails++; $display("FAIL b2b_rsp2: got %0d want 502", k2); end
    repeat (3) @(negedge CLK);
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: cmd_ready=%b want 1", bus.cmd_ready); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    int          rsp_seen;
    rsp_seen = 0;
    @(negedge CLK);
    bus.cmd_data = 8'h38; bus.cmd_rs = 1'b1; bus.cmd_rnw = 1'b0;
    bus.cmd_nibble_only = 1'b0; bus.cmd_wait_busy = 1'b0; bus.mode8bit = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    repeat (120) @(negedge CLK);
    tests++; if (LCD_E !== 1'b1) begin fails++; $display("FAIL rst_mid_e_high: E=%b want 1", LCD_E); end
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    got = {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data,
           LCD_E, LCD_RS, LCD_RW, LCD_D_OE, LCD_D_OUT};
    tests++; if (got !== 24'h800000) begin fails++; $display("FAIL rst_mid_outputs: got %h want 800000", got); end
    repeat (300) begin
      @(negedge CLK);
      if (bus.rsp_valid) rsp_seen++;
    end
    tests++; if (rsp_seen !== 0) begin fails++; $display("FAIL rst_mid_no_rsp: got %0d pulses want 0", rsp_seen); end
  endtask

  initial begin
    RESET_N = 1'b0;
    LCD_D_IN = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.cmd_rs = 1'b0; bus.cmd_rnw = 1'b0;
    bus.cmd_nibble_only = 1'b0; bus.cmd_wait_busy = 1'b0; bus.mode8bit = 1'b0;
    for (int i = 0; i < 16; i++) din_tab[i] = 8'h00;
    test_reset();
    test_write8();
    test_write4();
    test_nibble_only();
    test_poll8();
    test_poll4();
    test_read4();
`ifdef LCD_POLL_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_engine.md
Name: lcd_bus_engine

Overview:
- Parametrised HD44780-class LCD bus engine; successor to the single-nibble LCD transfer block.
- Performs full byte writes and reads (data or status) over a 4- or 8-bit bus, selected at runtime.
- Optional busy-flag polling after each operation; timings derived from clock frequency and nanosecond parameters.
- Sits between the LCD init/command sequencer (valid/ready command port) and the board pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- T_SETUP_NS, 2000, RS/RW/data setup time before E rises.
- T_PULSE_NS, 1000, E high time.
- T_HOLD_NS, 2000, time after E falls before the next phase.
- MAX_POLLS, 1000, busy-poll reads before timeout (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  synchronous reset, active low
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle; command accepted when cmd_valid & cmd_ready
- cmd_data  in  8  byte to write; ignored for reads
- cmd_rs  in  1  register select for the operation
- cmd_rnw  in  1  1 = read byte, 0 = write byte
- cmd_nibble_only  in  1  write high nibble only (4-bit init); ignored when mode8bit = 1
- cmd_wait_busy  in  1  poll busy flag after the operation
- mode8bit  in  1  bus width; sampled at accept
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  byte read (read op) or last status byte (poll); 0 otherwise
- rsp_timeout  out  1  valid with rsp_valid; poll limit reached
- LCD_D_OUT  out  8  data to pins; 4-bit mode uses [7:4], [3:0] = 0
- LCD_D_OE  out  1  pin driver enable
- LCD_D_IN  in  8  pin readback
- LCD_RS, LCD_RW, LCD_E  out  1  LCD control pins
- busy  out  1  high from accept to rsp_valid, inclusive

Behaviour:
- Cycle counts: S/P/H = ceil(CLK_FREQ_HZ * T_x_NS / 1e9), minimum 1. Defaults give S=100, P=50, H=100.
- Reset: all outputs 0 except cmd_ready = 1. State is IDLE. Any in-flight command is abandoned silently, with no rsp_valid.
- Accept edge: latch all cmd_* fields and mode8bit. Drive LCD_RS and LCD_RW = cmd_rnw. LCD_D_OE = !cmd_rnw. Place the first beat on LCD_D_OUT.
- States: IDLE -> SETUP(S) -> E_HIGH(P) -> E_LOW(H) -> NEXT.
- NEXT branching:
  - more beats -> SETUP;
  - else if wait_busy -> POLL;
  - else -> RESP.
- Beats: 8-bit mode = 1; 4-bit mode = 2, high nibble first (1 if cmd_nibble_only).
- Read capture: LCD_D_IN is captured on the last E_HIGH cycle. In 4-bit mode, [7:4] of each capture goes into the rsp_data high then low nibble.
- POLL: RS=0, RW=1, OE=0, then the same S/P/H beat sequence. Poll byte[7] = busy flag.
  - Busy = 1: poll again.
  - Busy = 0: go to RESP; rsp_data = poll byte.
  - In 4-bit mode both nibbles are always clocked, even when the busy flag is already clear.
- RESP: rsp_valid high for 1 cycle. Next cycle: IDLE, cmd_ready = 1, LCD_E = 0, OE = 0, RW = 0.
- Bus safety: LCD_D_OE is never 1 while LCD_RW = 1. When switching write->read, RW rises on the same edge OE falls.
- Latency without poll: rsp_valid occurs beats*(S+P+H) cycles after accept.
- Back-to-back: cmd_valid held high is accepted on the first IDLE cycle after RESP.
- cmd_valid while busy is ignored and not queued.

Optional Feature:
- Macro: LCD_POLL_TIMEOUT_EN.
- Defined: a poll counter counts completed poll reads. When MAX_POLLS reads all show busy = 1, go to RESP with rsp_timeout = 1 and rsp_data = last poll byte.
- Undefined: polling is unbounded, rsp_timeout is tied 0, and MAX_POLLS is unused.

Decomposition:
- Package lcd_pkg:
  - state enum lcd_bus_state_t;
  - function ns_to_cycles(freq, ns);
  - HD44780 status bit index BUSY_BIT = 7.
- Sub-module lcd_phase_timer: loadable down-counter with a done pulse, shared by the S/P/H phases.

Test Plan (defaults):
- 8-bit write 0x38, rs=0, wait_busy=0 -> D_OUT=0x38, OE=1, E high for exactly 50 cycles starting 100 cycles after accept, rsp_valid 250 cycles after accept.
- 4-bit write 0x41, rs=1 -> beat 1 D_OUT[7:4]=0x4, beat 2 D_OUT[7:4]=0x1, two E pulses, rsp_valid at 500, rsp_data=0.
- 4-bit nibble_only 0x30 -> single E pulse with D_OUT[7:4]=0x3, rsp_valid at 250.
- 8-bit write with wait_busy; model returns 0x85 for three polls then 0x05 -> four poll pulses with RW=1, OE=0, rsp_data=0x05, rsp_timeout=0.
- 4-bit read, rs=1; model drives 0xA on beat 1 and 0x7 on beat 2 -> rsp_data=0xA7.
- LCD_POLL_TIMEOUT_EN with MAX_POLLS=4 and model always busy (0x80) -> exactly 4 polls, rsp_timeout=1, rsp_data=0x80.
- RESET_N low mid E_HIGH -> next cycle all outputs 0, cmd_ready=1, no rsp_valid.
